// File: rtl/serial_rx_b13_if.sv
// Receive-side bundle for the b13 byte link: serial line in, held byte plus status out.
interface serial_rx_b13_if;
  logic       rx_in;
  logic       rd_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx_in,
    input  rd_ack,
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx_in,
    output rd_ack,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/serial_rx_b13.sv
// b13 serial receiver: 1 start, 8 data bits MSB first, 1 stop, mid-bit sampling,
// one-entry valid/ack holding register with sticky overrun.
module serial_rx_b13 #(
  parameter int unsigned BIT_PERIOD = 106
) (
  input  logic            clock,
  input  logic            reset,
  serial_rx_b13_if.master bus
);

  localparam int unsigned CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_PERIOD / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_s1;
  logic            r_rx_s;
  logic            r_rx_prev;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_nxt;
  logic [7:0]      r_shreg;
  logic [7:0]      w_shreg_nxt;
  logic            w_load;
  logic            w_ferr;
  logic [7:0]      r_data_out;
  logic            r_data_valid;
  logic            r_frame_err;
  logic            r_overrun;
  logic            r_busy;

  // Two-flop synchronizer plus previous-sample register for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1      <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_s1      <= bus.rx_in;
      r_rx_s    <= r_s1;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  // Frame sequencing; returning to IDLE at mid-stop lets back-to-back frames through.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_rx_prev && !r_rx_s) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt   = 3'd7;
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt          = '0;
          w_shreg_nxt[r_idx] = r_rx_s;
          if (r_idx == 3'd0) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_idx_nxt = r_idx - 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          if (r_rx_s) begin
            w_load = 1'b1;
          end else begin
            w_ferr = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Holding register: a good stop beats a same-cycle ack, so the new byte stays valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_load) begin
        r_data_out   <= r_shreg;
        r_data_valid <= 1'b1;
        r_overrun    <= bus.rd_ack ? 1'b0 : (r_overrun | r_data_valid);
      end else if (r_data_valid && bus.rd_ack) begin
        r_data_valid <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_serial_rx_b13.sv
// Bench for serial_rx_b13: table of frames with expected holding-register state,
// scoreboard popped whenever the receiver delivers a byte or a framing error.
module tb_serial_rx_b13;

  localparam int unsigned P   = 106;
  localparam int unsigned H   = P / 2;
  localparam int          LAT = 1010;

  logic clock = 1'b0;
  logic reset = 1'b1;

  serial_rx_b13_if bus ();

  serial_rx_b13 #(.BIT_PERIOD(P)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       err;
    logic [7:0] data;
    logic       valid;
    logic       ovr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack;
    int         gap;
    logic       exp_err;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: a delivery is a frame_err pulse or a new byte in the holding register.
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  int         last_evt_cyc = -1;

  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_ferr  = 1'b0;
      prev_data  = 8'h00;
    end else begin
      if (prev_ferr) chk("frame_err_one_cycle", 32'(bus.frame_err), 32'd0);
      if (bus.frame_err || (bus.data_valid && (!prev_valid || bus.data_out != prev_data))) begin
        exp_t e;
        last_evt_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: frame_err=%0b data_out=%02h with nothing expected",
                   bus.frame_err, bus.data_out);
        end else begin
          e = sb.pop_front();
          chk("frame_err", 32'(bus.frame_err), 32'(e.err));
          chk("data_out", 32'(bus.data_out), 32'(e.data));
          chk("data_valid", 32'(bus.data_valid), 32'(e.valid));
          chk("overrun", 32'(bus.overrun), 32'(e.ovr));
        end
      end
      prev_valid = bus.data_valid;
      prev_ferr  = bus.frame_err;
      prev_data  = bus.data_out;
    end
  end

  // One frame, start to end of stop bit; optional ack lands on the stop-sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_at_stop,
                            output int fall_cyc);
    logic [9:0] bits;
    bits = {1'b0, b, stop};
    @(posedge clock); #1;
    fall_cyc = cyc;
    for (int i = 9; i >= 1; i--) begin
      bus.rx_in = bits[i];
      repeat (P) @(posedge clock);
      #1;
    end
    bus.rx_in = stop;
    if (ack_at_stop) begin
      repeat (H + 2) @(posedge clock);
      #1 bus.rd_ack = 1'b1;
      @(negedge clock);
      chk("valid_held_before_load", 32'(bus.data_valid), 32'd1);
      @(posedge clock);
      #1 bus.rd_ack = 1'b0;
      repeat (P - H - 3) @(posedge clock);
      #1;
    end else begin
      repeat (P) @(posedge clock);
      #1;
    end
  endtask

  task automatic do_ack();
    @(posedge clock); #1 bus.rd_ack = 1'b1;
    @(posedge clock); #1 bus.rd_ack = 1'b0;
    @(negedge clock);
    chk("ack_clears_valid", 32'(bus.data_valid), 32'd0);
    chk("ack_clears_overrun", 32'(bus.overrun), 32'd0);
  endtask

  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   fall;
    int   bc;
    exp_t e;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'hC3, 1'b1, 1'b1, 8, 1'b0, 8'hC3, 1'b1, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 8, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b0, 8, 1'b0, 8'h81, 1'b1, 1'b0};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 8, 1'b0, 8'h7E, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 8, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, 8, 1'b1, 8'h00, 1'b1, 1'b0};

    bus.rx_in  = 1'b1;
    bus.rd_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clock);

    for (int v = 0; v < 8; v++) begin
      e = '{vecs[v].exp_err, vecs[v].exp_data, vecs[v].exp_valid, vecs[v].exp_ovr};
      sb.push_back(e);
      send_frame(vecs[v].data, vecs[v].stop, 1'b0, fall);
      bus.rx_in = 1'b1;
      chk("delivery_latency", 32'(last_evt_cyc - fall), 32'(LAT));
      if (vecs[v].ack) do_ack();
      repeat (vecs[v].gap) @(posedge clock);
    end

    // Ack on exactly the stop-sample cycle of a second unread byte: load wins, no overrun.
    sb.push_back('{1'b0, 8'h12, 1'b1, 1'b0});
    send_frame(8'h12, 1'b1, 1'b0, fall);
    sb.push_back('{1'b0, 8'h34, 1'b1, 1'b0});
    send_frame(8'h34, 1'b1, 1'b1, fall);
    chk("same_cycle_ack_latency", 32'(last_evt_cyc - fall), 32'(LAT));
    @(negedge clock);
    chk("same_cycle_ack_valid", 32'(bus.data_valid), 32'd1);
    chk("same_cycle_ack_data", 32'(bus.data_out), 32'h34);
    chk("same_cycle_ack_overrun", 32'(bus.overrun), 32'd0);

    // 20-clock low glitch on an idle line: false start, busy for exactly half a bit.
    bc = 0;
    bus.rx_in = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if (i == 20) bus.rx_in = 1'b1;
      if (bus.busy) bc++;
    end
    chk("false_start_busy_cycles", 32'(bc), 32'(H));
    chk("false_start_data_out", 32'(bus.data_out), 32'h34);
    chk("false_start_valid", 32'(bus.data_valid), 32'd1);
    chk("false_start_overrun", 32'(bus.overrun), 32'd0);

    // Reset halfway through data bit 4 clears everything without waiting for an edge.
    @(posedge clock); #1 bus.rx_in = 1'b0;
    repeat (P) @(posedge clock);
    #1 bus.rx_in = 1'b1;
    repeat (P) @(posedge clock);
    #1 bus.rx_in = 1'b0;
    repeat (P) @(posedge clock);
    #1 bus.rx_in = 1'b1;
    repeat (P) @(posedge clock);
    #1 bus.rx_in = 1'b0;
    repeat (H) @(posedge clock);
    #2;
    chk("midframe_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_data_out", 32'(bus.data_out), 32'd0);
    chk("async_rst_valid", 32'(bus.data_valid), 32'd0);
    chk("async_rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("async_rst_overrun", 32'(bus.overrun), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    bus.rx_in = 1'b1;
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);

    sb.push_back('{1'b0, 8'hF0, 1'b1, 1'b0});
    send_frame(8'hF0, 1'b1, 1'b0, fall);
    chk("post_reset_latency", 32'(last_evt_cyc - fall), 32'(LAT));

    repeat (10) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_rx_b13.md
# serial_rx_b13

Serial receiver for the b13 byte link: the far end of the `data_out` line driven by the b13 transmitter. The line idles high. Each frame is one start bit (0), then eight data bits sent MSB first (`out_reg[7]` down to `out_reg[0]`), then one stop bit (1); every bit lasts a fixed number of clock cycles. The block samples each bit at its midpoint, rebuilds the byte, checks the stop bit, and hands the byte to a consumer through a one-entry valid/ack holding register with overrun detection.

## Interface
- `BIT_PERIOD`, default 106: clock cycles per bit. Must be ≥ 4. The transmitter uses a delay of 104, so it emits one bit per 106 clocks.
- `clock`  in  1  single system clock; all logic updates on posedge.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `rx_in`  in  1  serial line; idle = 1. Asynchronous to `clock`, so it passes through a 2-flop synchronizer.
- `rd_ack`  in  1  consumer accepts the held byte. Only meaningful while `data_valid` = 1.
- `data_out`  out  8  last good received byte.
- `data_valid`  out  1  `data_out` holds an unread byte.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled as 0.
- `overrun`  out  1  sticky flag: a new byte overwrote an unread byte.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).

## Operation
- Synchronizer: `rx_in` → `s1` → `rx_s`, both reset to 1. Register `rx_prev` holds the previous `rx_s`, also reset to 1.
- Counter `cnt`: width $clog2(BIT_PERIOD). Resets to 0 on every state entry and on every sample. Never wraps past BIT_PERIOD-1.
- Bit index `idx`: 3 bits, counts 7 down to 0.
- Shift register `shreg`: 8 bits. A data bit is written to `shreg[idx]`.
- States:
  - IDLE: a start is detected when `rx_prev`=1 and `rx_s`=0. On detection: cnt←0, go to START. A line held low gives no new detection.
  - START: when cnt == BIT_PERIOD/2 − 1, sample `rx_s`.
    - If 1: false start, go to IDLE. No flags change.
    - Else: cnt←0, idx←7, go to DATA.
  - DATA: when cnt == BIT_PERIOD−1, do `shreg[idx]←rx_s` and cnt←0.
    - If idx == 0, go to STOP.
    - Else idx←idx−1.
  - STOP: when cnt == BIT_PERIOD−1, sample `rx_s` and go to IDLE.
    - Sample 1: `data_out←shreg`, `data_valid←1`. If `data_valid` was 1 and `rd_ack`=0 in the same cycle, `overrun←1`.
    - Sample 0: `frame_err`=1 for one cycle. Byte discarded; `data_out` and `data_valid` unchanged.
- Handshake:
  - `rd_ack`=1 while `data_valid`=1 clears `data_valid` and `overrun` at the next edge.
  - `rd_ack` while `data_valid`=0 is ignored.
  - `rd_ack` in the same cycle as a good stop: the load wins. `data_valid` stays 1, the new byte appears on `data_out`, and `overrun` stays 0.
- Reset, at any time including mid-frame:
  - state=IDLE; cnt, idx and shreg = 0.
  - `data_out`=0x00; `data_valid`, `frame_err`, `overrun` and `busy` = 0.
  - After reset the next frame needs a fresh falling edge.

## Timing
- Line fall to detection cycle D: 3 clocks (two synchronizer flops plus edge compare).
- Sample points, with P = BIT_PERIOD and H = P/2:
  - Start bit: D+H.
  - Data bit k, k = 1..8: D+H+k·P.
  - Stop bit: D+H+9P.
- `data_valid` (or the `frame_err` pulse) appears at D+H+9P+1. With the default period that is D+1008.
- `busy` is 1 from D+1 through the stop-sample cycle.
- Back-to-back frames are accepted. The stop-to-start falling edge is detected within a period of the stop sample, because the block returns to IDLE at mid-stop.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
- Reset with line idle, then send 0xA5 at 106 clocks/bit → `data_out`=0xA5, `data_valid`=1 at D+1008, `frame_err`=0, `overrun`=0. Pulse `rd_ack` → `data_valid`=0 on the next cycle.
- Send 0x3C then 0xC3 back to back with no `rd_ack` → `data_out`=0xC3, `data_valid`=1, `overrun`=1. A later `rd_ack` clears both `data_valid` and `overrun`.
- Frame 0x55 with a stop bit of 0 → one-cycle `frame_err` pulse; `data_valid` and `data_out` unchanged. A following good 0x81 is received correctly once the line has returned high and fallen again.
- Low glitch of 20 clocks on an idle line → false start: `busy` high for 53 cycles, then IDLE. No flags change.
- Assert `rd_ack` in exactly the cycle the second byte's stop is sampled → new byte valid, `overrun`=0.
- Assert `reset` halfway through bit 4 → all outputs 0 immediately (asynchronous). A frame 0xF0 sent afterwards is received as 0xF0.
